pooling_input_ctrl: RTL
=======================

POOLING_INPUT_CTRL -- requirements
Module: pooling_input_ctrl

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 6, words per row load and per shift burst.
REQ-002 SHALL have parameter ROW_WIDTH, default 3, width of row/block index.
REQ-003 SHALL have parameter NUM_ROWS, default 6, rows per feature map; range 1..2**ROW_WIDTH.
REQ-004 SHALL have parameter POOL_SIZE, default 2, pooling window edge; must divide KERNEL_SIZE and NUM_ROWS.
REQ-005 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  begin one feature-map pass; sampled only in IDLE.
REQ-008 SHALL have port rd_req  out  1  row fetch request to line memory.
REQ-009 SHALL have port rd_addr  out  ROW_WIDTH  row index requested.
REQ-010 SHALL have port rd_ack  in  1  row data present on shift buffer's data_in this cycle.
REQ-011 SHALL have port input_valid  out  1  parallel-load strobe to shift buffer.
REQ-012 SHALL have port block_idx  out  ROW_WIDTH  row index of word currently at buffer output.
REQ-013 SHALL have port out_valid  out  1  buffer output word valid this cycle.
REQ-014 SHALL have port col_first  out  1  word opens a horizontal pooling window.
REQ-015 SHALL have port row_first  out  1  current row opens a vertical pooling window.
REQ-016 SHALL have port win_last  out  1  word closes a full POOL_SIZE x POOL_SIZE window.
REQ-017 SHALL have port busy  out  1  high from start acceptance until done.
REQ-018 SHALL have port done  out  1  one-cycle pulse at pass completion.

Function
REQ-019 SHALL implement FSM IDLE -> FETCH -> SHIFT -> (FETCH | DONE) -> IDLE.
REQ-020 SHALL leave IDLE on start=1; rd_req rises the next cycle (start at cycle 0 -> rd_req at cycle 1).
REQ-021 SHALL, in FETCH, hold rd_req=1 and rd_addr=row counter until rd_ack=1; rd_ack outside FETCH SHALL be ignored.
REQ-022 SHALL drive input_valid = (state==FETCH) & rd_ack combinationally, exactly one cycle per row, then enter SHIFT.
REQ-023 SHALL, in SHIFT, assert out_valid for exactly KERNEL_SIZE consecutive cycles, shift counter 0..KERNEL_SIZE-1, input_valid=0 throughout.
REQ-024 SHALL drive col_first = out_valid & (shift_cnt mod POOL_SIZE == 0).
REQ-025 SHALL drive row_first = busy & (row mod POOL_SIZE == 0).
REQ-026 SHALL drive win_last = out_valid & (shift_cnt mod POOL_SIZE == POOL_SIZE-1) & (row mod POOL_SIZE == POOL_SIZE-1).
REQ-027 SHALL, on last shift cycle, go to FETCH with row+1 if row<NUM_ROWS-1, else to DONE.
REQ-028 SHALL pulse done=1 for one cycle in DONE, deassert busy same cycle, return to IDLE; row counter wraps to 0.
REQ-029 SHALL ignore start while busy or in DONE; start in IDLE the cycle after done SHALL be accepted.
REQ-030 SHALL keep block_idx equal to the row counter; it changes only on FETCH entry.

Reset
REQ-031 SHALL, on rst_n=0 at any time incl. mid-pass, force IDLE, counters 0, all outputs 0 immediately; no done pulse for aborted pass.
REQ-032 SHALL require a new start after reset release; no pass resumes.

Configuration
REQ-033 SHALL, with POOLING_CTRL_PERF_EN defined, add outputs fetch_wait_cnt (16-bit, FETCH cycles with rd_ack=0) and pass_cnt (16-bit, completed passes), both saturating, cleared by reset only.
REQ-034 SHALL, without POOLING_CTRL_PERF_EN, omit these ports and counters entirely.

Structure
REQ-035 SHALL take the FSM state enum and default parameter values from shared package pooling_pkg.
REQ-036 SHALL implement shift and row counters via one sub-module pooling_wrap_counter (enable, terminal value, wrap flag).

Verification
REQ-037 Reset defaults: start=1, rd_ack=1 held, rst_n=0 -> all outputs 0, no rd_req.
REQ-038 Full pass, rd_ack same cycle as rd_req: 6 loads, 36 out_valid cycles, 9 win_last pulses, done once, busy 0 after.
REQ-039 Slow memory: rd_ack 3 cycles late on row 2 -> rd_req/rd_addr=2 held 4 cycles, single input_valid.
REQ-040 start pulsed mid-SHIFT and in DONE cycle -> ignored; start the cycle after done -> new pass, rd_addr=0.
REQ-041 rst_n low during SHIFT of row 3 -> immediate IDLE, no done; restart completes normally.
REQ-042 PERF_EN build: two passes with 5 total wait cycles -> fetch_wait_cnt=5, pass_cnt=2.

Source files
------------

// File: rtl/pooling_pkg.sv
// Shared definitions for the pooling input controller: state encoding,
// default geometry and a counter-width helper.
package pooling_pkg;

  localparam int DEF_KERNEL_SIZE = 6;
  localparam int DEF_ROW_WIDTH   = 3;
  localparam int DEF_NUM_ROWS    = 6;
  localparam int DEF_POOL_SIZE   = 2;
  localparam int PERF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_e;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pooling_wrap_counter.sv
// Enabled up-counter that returns to zero after reaching a terminal value;
// wrap flags the enabled cycle in which that happens.
module pooling_wrap_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == term) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = en & (count_q == term);

endmodule

// File: rtl/pooling_input_ctrl.sv
// Row fetch / shift sequencer feeding a pooling shift buffer.
// Optional perf counters (fetch stalls, completed passes) under POOLING_CTRL_PERF_EN.
module pooling_input_ctrl
  import pooling_pkg::*;
#(
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int ROW_WIDTH   = DEF_ROW_WIDTH,
  parameter int NUM_ROWS    = DEF_NUM_ROWS,
  parameter int POOL_SIZE   = DEF_POOL_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 rd_req,
  output logic [ROW_WIDTH-1:0] rd_addr,
  input  logic                 rd_ack,
  output logic                 input_valid,
  output logic [ROW_WIDTH-1:0] block_idx,
  output logic                 out_valid,
  output logic                 col_first,
  output logic                 row_first,
  output logic                 win_last,
  output logic                 busy,
  output logic                 done
`ifdef POOLING_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] fetch_wait_cnt,
  output logic [PERF_CNT_WIDTH-1:0] pass_cnt
`endif
);

  localparam int SHIFT_W = cnt_width(KERNEL_SIZE);
  localparam logic [SHIFT_W-1:0]   SHIFT_TERM = SHIFT_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_TERM   = ROW_WIDTH'(NUM_ROWS - 1);

  pool_state_e          state_q;
  pool_state_e          state_d;
  logic                 shift_en;
  logic                 shift_wrap;
  logic [SHIFT_W-1:0]   shift_cnt;
  logic                 row_wrap;
  logic [ROW_WIDTH-1:0] row_cnt;
  logic                 row_last;
  logic                 col_phase0;
  logic                 col_phase_end;
  logic                 row_phase0;
  logic                 row_phase_end;

  // Word position inside the current row.
  pooling_wrap_counter #(
    .WIDTH (SHIFT_W)
  ) u_shift_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_en),
    .term  (SHIFT_TERM),
    .count (shift_cnt),
    .wrap  (shift_wrap)
  );

  // Row index advances when a row finishes shifting; it returns to zero
  // together with the move into DONE.
  pooling_wrap_counter #(
    .WIDTH (ROW_WIDTH)
  ) u_row_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_wrap),
    .term  (ROW_TERM),
    .count (row_cnt),
    .wrap  (row_wrap)
  );

  assign row_last = (row_cnt == ROW_TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_req      = 1'b0;
    input_valid = 1'b0;
    out_valid   = 1'b0;
    shift_en    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy   = 1'b1;
        rd_req = 1'b1;
        if (rd_ack) begin
          input_valid = 1'b1;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        shift_en  = 1'b1;
        if (shift_wrap) begin
          state_d = row_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign col_phase0    = ((32'(shift_cnt) % POOL_SIZE) == 0);
  assign col_phase_end = ((32'(shift_cnt) % POOL_SIZE) == (POOL_SIZE - 1));
  assign row_phase0    = ((32'(row_cnt) % POOL_SIZE) == 0);
  assign row_phase_end = ((32'(row_cnt) % POOL_SIZE) == (POOL_SIZE - 1));

  assign rd_addr   = row_cnt;
  assign block_idx = row_cnt;
  assign col_first = out_valid & col_phase0;
  assign row_first = busy & row_phase0;
  assign win_last  = out_valid & col_phase_end & row_phase_end;

`ifdef POOLING_CTRL_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] fetch_wait_cnt_q;
  logic [PERF_CNT_WIDTH-1:0] fetch_wait_cnt_d;
  logic [PERF_CNT_WIDTH-1:0] pass_cnt_q;
  logic [PERF_CNT_WIDTH-1:0] pass_cnt_d;

  // Both counters stick at all-ones rather than rolling over.
  always_comb begin
    fetch_wait_cnt_d = fetch_wait_cnt_q;
    pass_cnt_d       = pass_cnt_q;
    if (rd_req && !rd_ack && (fetch_wait_cnt_q != '1)) begin
      fetch_wait_cnt_d = fetch_wait_cnt_q + 1'b1;
    end
    if (done && (pass_cnt_q != '1)) begin
      pass_cnt_d = pass_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_wait_cnt_q <= '0;
      pass_cnt_q       <= '0;
    end else begin
      fetch_wait_cnt_q <= fetch_wait_cnt_d;
      pass_cnt_q       <= pass_cnt_d;
    end
  end

  assign fetch_wait_cnt = fetch_wait_cnt_q;
  assign pass_cnt       = pass_cnt_q;
`endif

endmodule
